// File: rtl/demo04.sv
// demo04: registered priority encoder with enable.
//
// Each rising clk edge samples the request vector In. When enabled and at
// least one request is active, Y gets the index of the winning request and
// Done goes high. Otherwise both are cleared, so Y=0/Done=0 always means
// "nothing". The result appears exactly one clock after the inputs are
// sampled.
//
// Parameters:
//   WIDTH     number of request inputs (power of two, >= 2)
//   LSB_FIRST 0: highest set index wins; 1: lowest set index wins
//   YW        encoded index width, derived as $clog2(WIDTH)
//
// Ports:
//   clk   system clock, rising edge
//   rst_n asynchronous active-low reset, clears Y and Done
//   EN    encoder enable, sampled each edge
//   In    request vector, bit i = request i active
//   Y     registered index of the winning request
//   Done  registered flag, high when Y holds a valid index
module demo04 #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b0,
    localparam int unsigned YW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EN,
    input  logic [WIDTH-1:0] In,
    output logic [YW-1:0]    Y,
    output logic             Done
);

    logic [YW-1:0] winner;
    logic          valid;

    // The scan order is chosen so the last match written is the winner:
    // ascending for highest-index priority, descending for lowest-index.
    always_comb begin
        winner = '0;
        if (LSB_FIRST) begin
            for (int unsigned i = WIDTH; i > 0; i--) begin
                if (In[i-1]) begin
                    winner = YW'(i - 1);
                end
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (In[i]) begin
                    winner = YW'(i);
                end
            end
        end
    end

    assign valid = EN & (|In);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y    <= '0;
            Done <= 1'b0;
        end else if (valid) begin
            Y    <= winner;
            Done <= 1'b1;
        end else begin
            Y    <= '0;
            Done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demo04.sv
// Directed testbench for demo04. Two instances share clk/rst_n/EN/In:
// u_msb uses highest-index priority, u_lsb uses lowest-index priority.
module tb_demo04;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] in_v;
    logic [2:0] y_msb;
    logic       done_msb;
    logic [2:0] y_lsb;
    logic       done_lsb;

    int n_cmp;
    int n_err;

    demo04 #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk  (clk),
        .rst_n(rst_n),
        .EN   (en),
        .In   (in_v),
        .Y    (y_msb),
        .Done (done_msb)
    );

    demo04 #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk  (clk),
        .rst_n(rst_n),
        .EN   (en),
        .In   (in_v),
        .Y    (y_lsb),
        .Done (done_lsb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs at a falling edge, then move to the following falling
    // edge so exactly one rising edge has captured them.
    task automatic apply(input logic e, input logic [7:0] v);
        en   = e;
        in_v = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en    = 1'b1;
        in_v  = 8'hFF;
        #1;
        n_cmp++;
        if (y_msb !== 3'd0 || done_msb !== 1'b0) begin
            n_err++;
            $display("FAIL reset_immediate: Y=%0d Done=%b, required Y=0 Done=0", y_msb, done_msb);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (y_msb !== 3'd0 || done_msb !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold_msb: Y=%0d Done=%b, required Y=0 Done=0", y_msb, done_msb);
        end
        n_cmp++;
        if (y_lsb !== 3'd0 || done_lsb !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold_lsb: Y=%0d Done=%b, required Y=0 Done=0", y_lsb, done_lsb);
        end
        rst_n = 1'b1;
        apply(1'b1, 8'hFF);
        n_cmp++;
        if (y_msb !== 3'd7 || done_msb !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_msb: Y=%0d Done=%b, required Y=7 Done=1", y_msb, done_msb);
        end
        n_cmp++;
        if (y_lsb !== 3'd0 || done_lsb !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_lsb: Y=%0d Done=%b, required Y=0 Done=1", y_lsb, done_lsb);
        end
    endtask

    task automatic test_disabled;
        apply(1'b0, 8'h00);
        n_cmp++;
        if (y_msb !== 3'd0 || done_msb !== 1'b0) begin
            n_err++;
            $display("FAIL disabled_zero: Y=%0d Done=%b, required Y=0 Done=0", y_msb, done_msb);
        end
        apply(1'b1, 8'h40);
        apply(1'b0, 8'h81);
        n_cmp++;
        if (y_msb !== 3'd0 || done_msb !== 1'b0) begin
            n_err++;
            $display("FAIL disabled_81_msb: Y=%0d Done=%b, required Y=0 Done=0", y_msb, done_msb);
        end
        n_cmp++;
        if (y_lsb !== 3'd0 || done_lsb !== 1'b0) begin
            n_err++;
            $display("FAIL disabled_81_lsb: Y=%0d Done=%b, required Y=0 Done=0", y_lsb, done_lsb);
        end
    endtask

    task automatic test_enabled_empty;
        apply(1'b1, 8'h20);
        apply(1'b1, 8'h00);
        n_cmp++;
        if (y_msb !== 3'd0 || done_msb !== 1'b0) begin
            n_err++;
            $display("FAIL enabled_empty: Y=%0d Done=%b, required Y=0 Done=0", y_msb, done_msb);
        end
    endtask

    task automatic test_priority;
        apply(1'b1, 8'b0011_1001);
        n_cmp++;
        if (y_msb !== 3'd5 || done_msb !== 1'b1) begin
            n_err++;
            $display("FAIL prio_39_msb: Y=%0d Done=%b, required Y=5 Done=1", y_msb, done_msb);
        end
        n_cmp++;
        if (y_lsb !== 3'd0 || done_lsb !== 1'b1) begin
            n_err++;
            $display("FAIL prio_39_lsb: Y=%0d Done=%b, required Y=0 Done=1", y_lsb, done_lsb);
        end
        apply(1'b1, 8'b0001_1000);
        n_cmp++;
        if (y_msb !== 3'd4 || done_msb !== 1'b1) begin
            n_err++;
            $display("FAIL prio_18_msb: Y=%0d Done=%b, required Y=4 Done=1", y_msb, done_msb);
        end
        n_cmp++;
        if (y_lsb !== 3'd3 || done_lsb !== 1'b1) begin
            n_err++;
            $display("FAIL prio_18_lsb: Y=%0d Done=%b, required Y=3 Done=1", y_lsb, done_lsb);
        end
        apply(1'b1, 8'b1000_0010);
        n_cmp++;
        if (y_msb !== 3'd7 || y_lsb !== 3'd1 || done_msb !== 1'b1 || done_lsb !== 1'b1) begin
            n_err++;
            $display("FAIL prio_82: Ymsb=%0d Ylsb=%0d Done=%b%b, required Ymsb=7 Ylsb=1 Done=11",
                     y_msb, y_lsb, done_msb, done_lsb);
        end
    endtask

    // Walk a single one through the request bits; before the capturing edge
    // the outputs must still show the previous result.
    task automatic test_sweep;
        logic [2:0] prev_y;
        logic [7:0] v;
        apply(1'b0, 8'h00);
        prev_y = 3'd0;
        for (int i = 0; i < 8; i++) begin
            v    = 8'h01 << i;
            en   = 1'b1;
            in_v = v;
            #1;
            n_cmp++;
            if (y_msb !== prev_y || done_msb !== (i != 0)) begin
                n_err++;
                $display("FAIL sweep_early_%0d: Y=%0d Done=%b, required Y=%0d Done=%b",
                         i, y_msb, done_msb, prev_y, (i != 0));
            end
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (y_msb !== 3'(i) || done_msb !== 1'b1 || y_lsb !== 3'(i) || done_lsb !== 1'b1) begin
                n_err++;
                $display("FAIL sweep_%0d: Ymsb=%0d Ylsb=%0d Done=%b%b, required Y=%0d Done=11",
                         i, y_msb, y_lsb, done_msb, done_lsb, i);
            end
            prev_y = 3'(i);
        end
    endtask

    task automatic test_async_reset;
        apply(1'b1, 8'hFF);
        n_cmp++;
        if (y_msb !== 3'd7 || done_msb !== 1'b1) begin
            n_err++;
            $display("FAIL async_pre: Y=%0d Done=%b, required Y=7 Done=1", y_msb, done_msb);
        end
        // Pulse reset well away from the next rising edge.
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (y_msb !== 3'd0 || done_msb !== 1'b0 || done_lsb !== 1'b0) begin
            n_err++;
            $display("FAIL async_clear: Y=%0d Done=%b%b, required Y=0 Done=00",
                     y_msb, done_msb, done_lsb);
        end
        #1;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (y_msb !== 3'd0 || done_msb !== 1'b0) begin
            n_err++;
            $display("FAIL async_no_survive: Y=%0d Done=%b, required Y=0 Done=0", y_msb, done_msb);
        end
        @(negedge clk);
        apply(1'b1, 8'b0011_1001);
        n_cmp++;
        if (y_msb !== 3'd5 || done_msb !== 1'b1 || y_lsb !== 3'd0 || done_lsb !== 1'b1) begin
            n_err++;
            $display("FAIL async_resume: Ymsb=%0d Ylsb=%0d Done=%b%b, required Ymsb=5 Ylsb=0 Done=11",
                     y_msb, y_lsb, done_msb, done_lsb);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        in_v  = 8'h00;
        @(negedge clk);
        test_reset();
        test_disabled();
        test_enabled_empty();
        test_priority();
        test_sweep();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded 20000 time units");
        $fatal(1);
    end

endmodule

// File: doc/demo04.md
Name: demo04

Overview:
- Registered 8-to-3 priority encoder with enable.
- Each clock it samples an 8-bit request vector and reports the index of the highest-numbered set bit on Y.
- It asserts Done when that index is valid.
- Used as a small request-arbitration/indexing leaf block; outputs are registered so they can feed timing-critical logic directly.

Parameters:
- WIDTH, 8, number of request inputs; must be a power of two, ≥2.
- YW, $clog2(WIDTH) (=3), width of the encoded index output; derived, not overridden.
- LSB_FIRST, 0, priority direction. 0 = highest index wins; 1 = lowest index wins.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- EN  input  1  encoder enable; sampled on each rising clk edge.
- In  input  WIDTH  request vector; bit i set = request i active.
- Y  output  YW  encoded index of the winning request (registered).
- Done  output  1  high when Y holds a valid index for the last sampled In (registered).

Behaviour:
- Reset
  - rst_n low forces Y=0 and Done=0 immediately, independent of clk.
  - Outputs hold those values while rst_n is low.
  - The first capture occurs on the first rising clk edge after rst_n deasserts.
- Combinational encode
  - LSB_FIRST=0: winner = largest i with In[i]=1.
  - LSB_FIRST=1: winner = smallest i with In[i]=1.
  - valid = EN & (|In).
- Register stage, on every rising clk edge:
  - valid=1: Y <= winner, Done <= 1.
  - valid=0 (EN=0, or In all zero): Y <= 0, Done <= 0. Y is cleared, not held, so Y=0 with Done=0 is unambiguous "nothing".
- Latency and timing
  - Exactly one clock: inputs sampled at edge N appear on Y/Done after edge N.
  - New result every cycle; no handshake or back-pressure.
  - Y=0 with Done=1 means request 0 won.
- Boundary conditions
  - EN=0 masks all requests regardless of In (e.g. In=8'h81 gives Done=0).
  - Multiple bits set: only the priority rule decides; other bits are ignored.
  - In=8'hFF gives Y=7 (LSB_FIRST=0) or Y=0 (LSB_FIRST=1), Done=1.
- Reset mid-operation: asynchronous assertion clears the outputs within the same cycle; no pending result survives reset.
- Structure
  - No internal state beyond the Y/Done registers.
  - No X propagation: the encoder is a full case/loop with default 0.

Test Plan:
1. Reset: hold rst_n=0 with EN=1, In=8'hFF across several clocks -> Y=0, Done=0. Release rst_n -> after next edge Y=7, Done=1.
2. Disabled: EN=0, In=8'h00 then EN=0, In=8'h81 -> Y=0, Done=0 after each edge.
3. Enabled, empty: EN=1, In=8'h00 -> Y=0, Done=0.
4. Multi-bit priority, LSB_FIRST=0, one edge each:
   - EN=1, In=8'b00111001 -> Y=5, Done=1.
   - In=8'b00011000 -> Y=4, Done=1.
5. Single-bit sweep: EN=1, In=8'b00001000 -> Y=3; In=8'b00010000 -> Y=4. Walk a one through bits 0..7 -> Y=0..7 with Done=1, each exactly one cycle after the input.
6. Async reset mid-stream, plus LSB_FIRST=1 variant:
   - Pulse rst_n low between edges -> outputs clear immediately without a clock edge.
   - LSB_FIRST=1 instance: In=8'b00111001 -> Y=0; In=8'b00011000 -> Y=3.
